// File: rtl/tomasulo_rs.sv
// ============================================================================
// Module   : tomasulo_rs
// Purpose  : Reservation station; holds waiting ops, snoops the CDB, issues oldest-ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tomasulo_rs_pkg;
    localparam int OP_W   = 4;
    localparam int TAG_W  = 4;
    localparam int WORD_W = 32;

    typedef logic [OP_W-1:0]   opcode_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic  vld;
        tag_t  tag;
        word_t wdata;
    } cdb_t;

    typedef struct packed {
        opcode_t     op;
        tag_t        tag;
        word_t [1:0] rdata;
    } issue_t;

    localparam int CDB_W = $bits(cdb_t);

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
endpackage

module tomasulo_rs
    import tomasulo_rs_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_vld,
    output logic                 disp_rdy,
    input  opcode_t              disp_op,
    input  tag_t                 disp_tag,
    input  logic [1:0]           disp_src_rdy,
    input  tag_t [1:0]           disp_src_tag,
    input  word_t [1:0]          disp_src_data,
    input  cdb_t                 cdb,
    input  logic                 iss_stall,
    output logic                 iss_vld_r,
    output issue_t               iss_r,
    output logic [$clog2(N+1)-1:0] occ_r
);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]  ent_vld;
    opcode_t       ent_op   [N];
    tag_t          ent_tag  [N];
    logic [1:0]    ent_rdy  [N];
    tag_t          ent_stag [N][2];
    word_t         ent_data [N][2];
    // older[i][j] set means entry i was dispatched before entry j
    logic [N-1:0]  older    [N];

    logic [N-1:0]  elig;
    logic [N-1:0]  sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic          any_elig;
    logic          disp_fire;
    logic          iss_fire;

    assign disp_rdy  = |(~ent_vld);
    assign disp_fire = disp_vld & disp_rdy;
    assign any_elig  = |elig;
    assign iss_fire  = any_elig & ~iss_stall;

    always_comb begin
        elig     = '0;
        sel_oh   = '0;
        sel_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = ent_vld[i] & ent_rdy[i][0] & ent_rdy[i][1];
        end
        for (int i = 0; i < N; i++) begin
            sel_oh[i] = elig[i];
            for (int j = 0; j < N; j++) begin
                if (elig[j] && older[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (sel_oh[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld   <= '0;
            iss_vld_r <= 1'b0;
            iss_r     <= '0;
            occ_r     <= '0;
            for (int i = 0; i < N; i++) begin
                ent_op[i]  <= '0;
                ent_tag[i] <= '0;
                ent_rdy[i] <= '0;
                older[i]   <= '0;
                for (int s = 0; s < 2; s++) begin
                    ent_stag[i][s] <= '0;
                    ent_data[i][s] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < 2; s++) begin
                    if (ent_vld[i] && !ent_rdy[i][s] && cdb.vld && cdb.tag == ent_stag[i][s]) begin
                        ent_rdy[i][s]  <= 1'b1;
                        ent_data[i][s] <= cdb.wdata;
                    end
                end
            end

            if (disp_fire) begin
                ent_vld[free_idx] <= 1'b1;
                ent_op[free_idx]  <= disp_op;
                ent_tag[free_idx] <= disp_tag;
                for (int s = 0; s < 2; s++) begin
                    ent_stag[free_idx][s] <= disp_src_tag[s];
                    if (disp_src_rdy[s]) begin
                        ent_rdy[free_idx][s]  <= 1'b1;
                        ent_data[free_idx][s] <= disp_src_data[s];
                    end else if (cdb.vld && cdb.tag == disp_src_tag[s]) begin
                        ent_rdy[free_idx][s]  <= 1'b1;
                        ent_data[free_idx][s] <= cdb.wdata;
                    end else begin
                        ent_rdy[free_idx][s]  <= 1'b0;
                        ent_data[free_idx][s] <= '0;
                    end
                end
                // Newcomer is younger than everyone; stale bits of free slots are rewritten on their own dispatch
                older[free_idx] <= '0;
                for (int j = 0; j < N; j++) begin
                    if (j != int'(free_idx)) begin
                        older[j][free_idx] <= 1'b1;
                    end
                end
            end

            if (!iss_stall) begin
                iss_vld_r <= any_elig;
                if (any_elig) begin
                    iss_r            <= {ent_op[sel_idx], ent_tag[sel_idx],
                                         ent_data[sel_idx][0], ent_data[sel_idx][1]};
                    ent_vld[sel_idx] <= 1'b0;
                end
            end

            occ_r <= occ_r + ($clog2(N+1))'(disp_fire) - ($clog2(N+1))'(iss_fire);
        end
    end

    a_no_full_dispatch: assert property (@(posedge clk) disable iff (rst) !(disp_vld && !disp_rdy));

endmodule

`default_nettype wire

// File: tb/tb_tomasulo_rs.sv
// Testbench for tomasulo_rs: directed vector table, corner sequences, and a randomized queue model.
`default_nettype none

module tb_tomasulo_rs;
    import tomasulo_rs_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_vld;
    logic        disp_rdy;
    opcode_t     disp_op;
    tag_t        disp_tag;
    logic [1:0]  disp_src_rdy;
    tag_t [1:0]  disp_src_tag;
    word_t [1:0] disp_src_data;
    cdb_t        cdb;
    logic        iss_stall;
    logic        iss_vld_r;
    issue_t      iss_r;
    logic [$clog2(N+1)-1:0] occ_r;

    int checks   = 0;
    int failures = 0;

    tomasulo_rs #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_op(disp_op), .disp_tag(disp_tag),
        .disp_src_rdy(disp_src_rdy), .disp_src_tag(disp_src_tag), .disp_src_data(disp_src_data),
        .cdb(cdb), .iss_stall(iss_stall),
        .iss_vld_r(iss_vld_r), .iss_r(iss_r), .occ_r(occ_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input opcode_t op, input tag_t tg, input logic [1:0] sr,
                              input tag_t t0, input tag_t t1, input word_t d0, input word_t d1);
        disp_vld         = 1'b1;
        disp_op          = op;
        disp_tag         = tg;
        disp_src_rdy     = sr;
        disp_src_tag[0]  = t0;
        disp_src_tag[1]  = t1;
        disp_src_data[0] = d0;
        disp_src_data[1] = d1;
    endtask

    function automatic logic [71:0] iss_word(input opcode_t op, input tag_t tg, input word_t a, input word_t b);
        return {op, tg, a, b};
    endfunction

    typedef struct {
        opcode_t    op;
        tag_t       tag;
        logic [1:0] srdy;
        tag_t       st0, st1;
        word_t      sd0, sd1;
        cdb_t       c0, c1;
        word_t      e0, e1;
        int         lat;
    } vec_t;

    typedef struct packed {
        opcode_t     op;
        tag_t        tag;
        logic [1:0]  rdy;
        tag_t [1:0]  st;
        word_t [1:0] d;
    } ment_t;

    vec_t  vt[5];
    ment_t mq[$];

    initial begin
        int          lat;
        logic        got;
        logic        exp_vld;
        logic [71:0] exp_iss;
        logic        dv, stl;
        ment_t       e;
        int          found;

        rst = 1'b1; disp_vld = 1'b0; disp_op = '0; disp_tag = '0; disp_src_rdy = '0;
        disp_src_tag = '0; disp_src_data = '0; cdb = '0; iss_stall = 1'b0;
        #12;
        check("reset_iss_vld", iss_vld_r, 0);
        check("reset_occ", occ_r, 0);
        check("reset_disp_rdy", disp_rdy, 1);
        check("reset_iss_r", iss_r, 0);
        @(posedge clk); #1; rst = 1'b0;

        vt[0] = '{OP_ADD, 4'd5, 2'b11, 4'd0, 4'd0, 32'd3, 32'd4, '0, '0, 32'd3, 32'd4, 2};
        vt[1] = '{OP_SUB, 4'd2, 2'b00, 4'd7, 4'd7, 32'd0, 32'd0, '0,
                  '{vld:1'b1, tag:4'd7, wdata:32'h10}, 32'h10, 32'h10, 3};
        vt[2] = '{OP_ADD, 4'd6, 2'b01, 4'd0, 4'd9, 32'h22, 32'd0,
                  '{vld:1'b1, tag:4'd9, wdata:32'hAB}, '0, 32'h22, 32'hAB, 2};
        vt[3] = '{OP_SUB, 4'd3, 2'b00, 4'd9, 4'd9, 32'd0, 32'd0,
                  '{vld:1'b0, tag:4'd9, wdata:32'h77}, '{vld:1'b1, tag:4'd9, wdata:32'h99},
                  32'h99, 32'h99, 3};
        vt[4] = '{OP_ADD, 4'd1, 2'b10, 4'd3, 4'd0, 32'd0, 32'd5,
                  '{vld:1'b1, tag:4'd4, wdata:32'h1}, '{vld:1'b1, tag:4'd3, wdata:32'hCAFE},
                  32'hCAFE, 32'd5, 3};

        for (int v = 0; v < 5; v++) begin
            drive_disp(vt[v].op, vt[v].tag, vt[v].srdy, vt[v].st0, vt[v].st1, vt[v].sd0, vt[v].sd1);
            cdb = vt[v].c0;
            tick();
            disp_vld = 1'b0;
            cdb = vt[v].c1;
            got = 1'b0; lat = 0;
            for (int k = 2; k <= 8 && !got; k++) begin
                tick();
                cdb = '0;
                if (iss_vld_r) begin got = 1'b1; lat = k; end
            end
            check($sformatf("vec%0d_latency", v), lat, vt[v].lat);
            check($sformatf("vec%0d_iss", v), iss_r, iss_word(vt[v].op, vt[v].tag, vt[v].e0, vt[v].e1));
            check($sformatf("vec%0d_occ", v), occ_r, 0);
            tick();
            check($sformatf("vec%0d_idle", v), iss_vld_r, 0);
        end

        // Oldest-first drain from a full station
        for (int t = 1; t <= 4; t++) begin
            drive_disp(OP_ADD, tag_t'(t), 2'b00, 4'd8, 4'd8, 32'd0, 32'd0);
            tick();
        end
        disp_vld = 1'b0;
        check("full_disp_rdy", disp_rdy, 0);
        check("full_occ", occ_r, 4);
        cdb = '{vld:1'b1, tag:4'd8, wdata:32'h55};
        tick();
        cdb = '0;
        check("full_no_early_issue", iss_vld_r, 0);
        for (int t = 1; t <= 4; t++) begin
            tick();
            check($sformatf("order_vld%0d", t), iss_vld_r, 1);
            check($sformatf("order_tag%0d", t), iss_r.tag, t);
            if (t == 1) check("freed_disp_rdy", disp_rdy, 1);
        end
        tick();
        check("order_done", iss_vld_r, 0);

        // Stall holds the issue register while entries wait
        drive_disp(OP_SUB, 4'd12, 2'b11, 4'd0, 4'd0, 32'd1, 32'd2);
        tick();
        drive_disp(OP_ADD, 4'd10, 2'b11, 4'd0, 4'd0, 32'd3, 32'd4);
        tick();
        check("stall_pre_tag", iss_r, iss_word(OP_SUB, 4'd12, 32'd1, 32'd2));
        drive_disp(OP_ADD, 4'd11, 2'b11, 4'd0, 4'd0, 32'd5, 32'd6);
        iss_stall = 1'b1;
        tick();
        disp_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("stall_hold_iss", iss_r, iss_word(OP_SUB, 4'd12, 32'd1, 32'd2));
            check("stall_hold_vld", iss_vld_r, 1);
            check("stall_occ", occ_r, 2);
            if (c < 2) tick();
        end
        iss_stall = 1'b0;
        tick();
        check("stall_rel1", iss_r, iss_word(OP_ADD, 4'd10, 32'd3, 32'd4));
        tick();
        check("stall_rel2", iss_r, iss_word(OP_ADD, 4'd11, 32'd5, 32'd6));
        tick();
        check("stall_idle", iss_vld_r, 0);
        check("stall_occ_end", occ_r, 0);

        // Asynchronous reset with three entries in flight
        for (int t = 1; t <= 3; t++) begin
            drive_disp(OP_ADD, tag_t'(t), 2'b00, 4'd15, 4'd15, 32'd0, 32'd0);
            tick();
        end
        disp_vld = 1'b0;
        check("pre_rst_occ", occ_r, 3);
        #2; rst = 1'b1; #1;
        check("rst_iss_vld", iss_vld_r, 0);
        check("rst_occ", occ_r, 0);
        check("rst_disp_rdy", disp_rdy, 1);
        @(posedge clk); #1; rst = 1'b0;
        cdb = '{vld:1'b1, tag:4'd15, wdata:32'h1};
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_no_issue", iss_vld_r, 0);
        end
        cdb = '0;

        // Randomized traffic against a queue model kept in age order
        mq.delete();
        exp_vld = 1'b0;
        exp_iss = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            dv  = ($urandom_range(0, 1) == 1) && (mq.size() < N);
            stl = ($urandom_range(0, 3) == 0);
            drive_disp(opcode_t'($urandom_range(0, 15)), tag_t'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3)), tag_t'($urandom_range(0, 7)), tag_t'($urandom_range(0, 7)),
                       $urandom, $urandom);
            disp_vld  = dv;
            iss_stall = stl;
            cdb.vld   = ($urandom_range(0, 1) == 1);
            cdb.tag   = tag_t'($urandom_range(0, 7));
            cdb.wdata = $urandom;
            check("rand_disp_rdy", disp_rdy, mq.size() < N);

            if (!stl) begin
                found = -1;
                for (int i = 0; i < mq.size(); i++) begin
                    if (found < 0 && mq[i].rdy == 2'b11) found = i;
                end
                if (found >= 0) begin
                    exp_vld = 1'b1;
                    exp_iss = iss_word(mq[found].op, mq[found].tag, mq[found].d[0], mq[found].d[1]);
                    mq.delete(found);
                end else begin
                    exp_vld = 1'b0;
                end
            end
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                for (int s = 0; s < 2; s++) begin
                    if (!e.rdy[s] && cdb.vld && cdb.tag == e.st[s]) begin
                        e.rdy[s] = 1'b1;
                        e.d[s]   = cdb.wdata;
                    end
                end
                mq[i] = e;
            end
            if (dv) begin
                e.op  = disp_op;
                e.tag = disp_tag;
                for (int s = 0; s < 2; s++) begin
                    e.st[s] = disp_src_tag[s];
                    if (disp_src_rdy[s]) begin
                        e.rdy[s] = 1'b1; e.d[s] = disp_src_data[s];
                    end else if (cdb.vld && cdb.tag == disp_src_tag[s]) begin
                        e.rdy[s] = 1'b1; e.d[s] = cdb.wdata;
                    end else begin
                        e.rdy[s] = 1'b0; e.d[s] = '0;
                    end
                end
                mq.push_back(e);
            end

            tick();
            check("rand_iss_vld", iss_vld_r, exp_vld);
            if (exp_vld) check("rand_iss_r", iss_r, exp_iss);
            check("rand_occ", occ_r, mq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
